// File: rtl/sha256_wb_pkg.sv
// Shared types and constants for the SHA-256 digest writeback stage.
package sha256_wb_pkg;

    localparam int ADDR_W = 16;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } wb_state_e;

    // h[0] is h0; packed so a whole digest moves as one vector.
    typedef struct packed {
        logic [7:0][WORD_W-1:0] h;
    } digest_t;

endpackage

// File: rtl/sha256_digest_writeback_fifo.sv
// Small synchronous FIFO of digests; head is read combinationally.
module digest_fifo
    import sha256_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    clr,
    input  logic    push,
    input  logic    pop,
    input  digest_t din,
    output digest_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    digest_t     mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; clear wins over any push/pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full && !clr) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sha256_digest_writeback.sv
// Buffers finished SHA-256 digests and writes 1 or 8 words of each to
// consecutive memory slots starting at a per-job base address.
module sha256_digest_writeback
    import sha256_wb_pkg::*;
#(
    parameter int FIFO_DEPTH       = 4,
    parameter int WORDS_PER_DIGEST = 1,
    parameter int NUM_NONCES       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_h0,
    input  logic [WORD_W-1:0] in_h1,
    input  logic [WORD_W-1:0] in_h2,
    input  logic [WORD_W-1:0] in_h3,
    input  logic [WORD_W-1:0] in_h4,
    input  logic [WORD_W-1:0] in_h5,
    input  logic [WORD_W-1:0] in_h6,
    input  logic [WORD_W-1:0] in_h7,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_write_data,
    output logic              done
);

    wb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  wr_q, wr_d;
    logic [2:0]        widx_q, widx_d;
    digest_t           dig_q, dig_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wd_q, wd_d;

    digest_t in_dig, fifo_head;
    logic    fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
    logic    issue;

    assign in_dig = digest_t'({in_h7, in_h6, in_h5, in_h4, in_h3, in_h2, in_h1, in_h0});

    // Ready depends only on registered state, so a pop never opens a full FIFO early.
    assign in_ready  = (state_q != IDLE) && !fifo_full && (acc_q < CNT_W'(NUM_NONCES));
    assign fifo_push = in_valid && in_ready;

    digest_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (fifo_clr),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (in_dig),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state, counters and the word to issue this cycle.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        acc_d    = acc_q + CNT_W'(fifo_push);
        wr_d     = wr_q;
        widx_d   = widx_q;
        dig_d    = dig_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        fifo_pop = 1'b0;
        fifo_clr = 1'b0;
        issue    = 1'b0;
        case (state_q)
            IDLE: begin
                we_d = 1'b0;
                if (start) begin
                    base_d   = output_addr;
                    acc_d    = '0;
                    wr_d     = '0;
                    widx_d   = '0;
                    fifo_clr = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    dig_d    = fifo_head;
                    widx_d   = '0;
                    issue    = 1'b1;
                    state_d  = WRITE;
                end else begin
                    we_d = 1'b0;
                end
            end
            WRITE: begin
                if (widx_q < 3'(WORDS_PER_DIGEST - 1)) begin
                    widx_d = widx_q + 3'd1;
                    issue  = 1'b1;
                end else begin
                    wr_d = wr_q + CNT_W'(1);
                    if (wr_d == CNT_W'(NUM_NONCES)) begin
                        we_d    = 1'b0;
                        state_d = IDLE;
                    end else if (!fifo_empty) begin
                        // Back-to-back digest: no idle cycle between them.
                        fifo_pop = 1'b1;
                        dig_d    = fifo_head;
                        widx_d   = '0;
                        issue    = 1'b1;
                    end else begin
                        we_d    = 1'b0;
                        state_d = WAIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            we_d   = 1'b1;
            addr_d = base_q + ADDR_W'(32'(wr_d) * WORDS_PER_DIGEST) + ADDR_W'(widx_d);
            wd_d   = dig_d.h[widx_d];
        end
    end

    // State, counters and memory-port registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            acc_q   <= '0;
            wr_q    <= '0;
            widx_q  <= '0;
            dig_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
            widx_q  <= widx_d;
            dig_q   <= dig_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
        end
    end

    assign mem_clk        = clk;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wd_q;
    assign done           = (state_q == IDLE);

endmodule

// File: tb/tb_sha256_digest_writeback.sv
// Bench for sha256_digest_writeback: four differently configured instances,
// a per-cycle reference model of the write stream and handshake, plus
// hand-computed address/data checks per scenario.
module tb_sha256_digest_writeback;

    localparam int NI = 4;

    // Instance 0: defaults; 1: full digests x2; 2: depth-2 backpressure; 3: address wrap.
    function automatic int p_fd(int i);
        return (i == 2) ? 2 : 4;
    endfunction
    function automatic int p_wpd(int i);
        return (i == 1 || i == 2) ? 8 : 1;
    endfunction
    function automatic int p_nn(int i);
        case (i)
            0:       return 16;
            1:       return 2;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_r  [NI];
    logic [15:0] oaddr    [NI];
    logic        in_valid [NI];
    logic [31:0] in_h     [NI][8];
    logic        in_ready [NI];
    logic        mclk     [NI];
    logic        mem_we   [NI];
    logic [15:0] mem_addr [NI];
    logic [31:0] mem_wd   [NI];
    logic        done     [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sha256_digest_writeback #(
            .FIFO_DEPTH       (p_fd(g)),
            .WORDS_PER_DIGEST (p_wpd(g)),
            .NUM_NONCES       (p_nn(g))
        ) u_dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .start          (start_r[g]),
            .output_addr    (oaddr[g]),
            .in_valid       (in_valid[g]),
            .in_ready       (in_ready[g]),
            .in_h0          (in_h[g][0]),
            .in_h1          (in_h[g][1]),
            .in_h2          (in_h[g][2]),
            .in_h3          (in_h[g][3]),
            .in_h4          (in_h[g][4]),
            .in_h5          (in_h[g][5]),
            .in_h6          (in_h[g][6]),
            .in_h7          (in_h[g][7]),
            .mem_clk        (mclk[g]),
            .mem_we         (mem_we[g]),
            .mem_addr       (mem_addr[g]),
            .mem_write_data (mem_wd[g]),
            .done           (done[g])
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    // Reference model state: a job is a list of accepted digests; the writer
    // emits their words in order, one per cycle, starting no earlier than two
    // samples after the digest was handed over.
    bit          m_idle [NI];
    logic [15:0] m_base [NI];
    int          m_acc  [NI];
    int          m_wr   [NI];
    int          m_hs   [NI][$];
    logic [31:0] m_dq   [NI][$];
    logic [15:0] m_la   [NI];
    logic [31:0] m_ld   [NI];
    logic [15:0] lg_a   [NI][$];
    logic [31:0] lg_d   [NI][$];
    int          lg_t   [NI][$];
    int          cyc = 0;

    task automatic model_step(input int i);
        int k, n, wpd, started;
        bit ew, er, idle0;
        wpd = p_wpd(i);
        if (!reset_n) begin
            chk("rst_we",   i, 32'(mem_we[i]), 32'd0);
            chk("rst_done", i, 32'(done[i]),   32'd1);
            chk("rst_rdy",  i, 32'(in_ready[i]), 32'd0);
            chk("rst_addr", i, 32'(mem_addr[i]), 32'd0);
            chk("rst_data", i, mem_wd[i], 32'd0);
            m_idle[i] = 1'b1; m_acc[i] = 0; m_wr[i] = 0;
            m_hs[i].delete(); m_dq[i].delete();
            m_la[i] = '0; m_ld[i] = '0;
            return;
        end
        idle0 = m_idle[i];
        ew = 1'b0;
        k = m_wr[i] / wpd;
        n = m_wr[i] % wpd;
        if (!idle0) begin
            if (n != 0) ew = 1'b1;
            else if (m_hs[i].size() > k && m_hs[i][k] <= cyc - 2) ew = 1'b1;
        end
        if (ew) begin
            m_la[i] = m_base[i] + 16'(m_wr[i]);
            m_ld[i] = m_dq[i][k*8 + n];
        end
        started = (m_wr[i] + int'(ew) + wpd - 1) / wpd;
        er = !idle0 && ((m_acc[i] - started) < p_fd(i)) && (m_acc[i] < p_nn(i));
        chk("mem_we",   i, 32'(mem_we[i]),   32'(ew));
        chk("done",     i, 32'(done[i]),     32'(idle0));
        chk("in_ready", i, 32'(in_ready[i]), 32'(er));
        chk("mem_addr", i, 32'(mem_addr[i]), 32'(m_la[i]));
        chk("mem_data", i, mem_wd[i], m_ld[i]);
        chk("mem_clk",  i, 32'(mclk[i]), 32'(clk));
        if (ew) begin
            lg_a[i].push_back(mem_addr[i]);
            lg_d[i].push_back(mem_wd[i]);
            lg_t[i].push_back(cyc);
            m_wr[i]++;
            if (m_wr[i] == p_nn(i) * wpd) m_idle[i] = 1'b1;
        end
        if (idle0 && start_r[i]) begin
            m_idle[i] = 1'b0; m_base[i] = oaddr[i];
            m_acc[i] = 0; m_wr[i] = 0;
            m_hs[i].delete(); m_dq[i].delete();
            lg_a[i].delete(); lg_d[i].delete(); lg_t[i].delete();
        end
        if (er && in_valid[i]) begin
            for (int w = 0; w < 8; w++) m_dq[i].push_back(in_h[i][w]);
            m_hs[i].push_back(cyc);
            m_acc[i]++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NI; i++) model_step(i);
        end
    end

    task automatic do_start(input int i, input logic [15:0] b);
        @(posedge clk); #1;
        oaddr[i] = b; start_r[i] = 1'b1;
        @(posedge clk); #1;
        start_r[i] = 1'b0;
    endtask

    // Offer cnt digests; word n of digest d is hb + (n<<16) + d.
    task automatic feed(input int i, input logic [31:0] hb, input int cnt, input bit hold);
        bit acc;
        int guard;
        for (int d = 0; d < cnt; d++) begin
            in_valid[i] = 1'b1;
            for (int w = 0; w < 8; w++) in_h[i][w] = hb + (32'(w) << 16) + 32'(d);
            acc = 1'b0; guard = 0;
            while (!acc && guard < 200) begin
                @(negedge clk);
                if (in_ready[i]) acc = 1'b1; else guard++;
            end
            if (!acc) chk("accept_timeout", i, 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        if (hold) begin
            for (int w = 0; w < 8; w++) in_h[i][w] = 32'hDEAD_0000 + 32'(w);
        end else begin
            in_valid[i] = 1'b0;
        end
    endtask

    task automatic wait_done(input int i);
        int guard;
        guard = 0;
        while (!done[i] && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk("done_timeout", i, 32'(done[i]), 32'd1);
        in_valid[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string nm, input int i, input int idx, input logic [15:0] a, input logic [31:0] d);
        if (lg_a[i].size() > idx) begin
            chk({nm, "_addr"}, i, 32'(lg_a[i][idx]), 32'(a));
            chk({nm, "_data"}, i, lg_d[i][idx], d);
        end else begin
            chk({nm, "_missing"}, i, 32'(lg_a[i].size()), 32'(idx + 1));
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            start_r[i] = 1'b0; oaddr[i] = '0; in_valid[i] = 1'b0;
            for (int w = 0; w < 8; w++) in_h[i][w] = '0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_done", 0, 32'(done[0]), 32'd1);
        chk("lit_rst_we",   0, 32'(mem_we[0]), 32'd0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // Single-word mode, one digest per cycle.
        do_start(0, 16'h0100);
        feed(0, 32'hA000_0000, 16, 1'b0);
        wait_done(0);
        chk("lit_a_cnt", 0, 32'(lg_a[0].size()), 32'd16);
        chk_log("lit_a0",  0, 0,  16'h0100, 32'hA000_0000);
        chk_log("lit_a15", 0, 15, 16'h010F, 32'hA000_000F);
        if (lg_t[0].size() == 16) chk("lit_a_span", 0, 32'(lg_t[0][15] - lg_t[0][0]), 32'd15);

        // Full-digest mode, two digests back to back.
        do_start(1, 16'h0020);
        feed(1, 32'hB000_0000, 2, 1'b0);
        wait_done(1);
        chk("lit_b_cnt", 1, 32'(lg_a[1].size()), 32'd16);
        chk_log("lit_b0",  1, 0,  16'h0020, 32'hB000_0000);
        chk_log("lit_b8",  1, 8,  16'h0028, 32'hB000_0001);
        chk_log("lit_b15", 1, 15, 16'h002F, 32'hB007_0001);
        if (lg_t[1].size() == 16) chk("lit_b_nobubble", 1, 32'(lg_t[1][15] - lg_t[1][0]), 32'd15);

        // Backpressure: depth 2, in_valid held high past the job limit.
        do_start(2, 16'h0400);
        feed(2, 32'hC000_0000, 3, 1'b1);
        wait_done(2);
        chk("lit_c_cnt", 2, 32'(lg_a[2].size()), 32'd24);
        chk_log("lit_c16", 2, 16, 16'h0410, 32'hC000_0002);
        chk_log("lit_c23", 2, 23, 16'h0417, 32'hC007_0002);

        // Address wrap across 0xFFFF.
        do_start(3, 16'hFFFE);
        feed(3, 32'hD000_0000, 4, 1'b0);
        wait_done(3);
        chk_log("lit_w0", 3, 0, 16'hFFFE, 32'hD000_0000);
        chk_log("lit_w1", 3, 1, 16'hFFFF, 32'hD000_0001);
        chk_log("lit_w2", 3, 2, 16'h0000, 32'hD000_0002);
        chk_log("lit_w3", 3, 3, 16'h0001, 32'hD000_0003);

        // Reset while the third digest is being written, then a fresh job.
        do_start(0, 16'h0300);
        feed(0, 32'h9000_0000, 4, 1'b1);
        chk("mid_we", 0, 32'(mem_we[0]), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("async_rst_we", 0, 32'(mem_we[0]), 32'd0);
        in_valid[0] = 1'b0;
        @(negedge clk); #1;
        reset_n = 1'b1;
        do_start(0, 16'h0200);
        feed(0, 32'hE000_0000, 16, 1'b0);
        wait_done(0);
        chk("lit_r_cnt", 0, 32'(lg_a[0].size()), 32'd16);
        chk_log("lit_r0",  0, 0,  16'h0200, 32'hE000_0000);
        chk_log("lit_r15", 0, 15, 16'h020F, 32'hE000_000F);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sha256_digest_writeback.md
# sha256_digest_writeback

Downstream stage of the SHA-256 core in the bitcoin hash path. Accepts completed digests (h0..h7) over a valid/ready handshake, buffers them in a small FIFO, and writes either the first word or all eight words of each digest to memory at consecutive slots from `output_addr`. It drives the shared memory port's write side while the hash core keeps computing the next nonce. `done` rises once `NUM_NONCES` digests have been written.

## Interface
- `FIFO_DEPTH`, default 4: digest buffer entries; power of two, ≥2.
- `WORDS_PER_DIGEST`, default 1: memory words per digest; legal values are 1 (h0 only) and 8 (h0..h7).
- `NUM_NONCES`, default 16: digests per job, 1..255.
- `clk` in 1: single clock. Memory writes are issued on this clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begins a job; sampled only in IDLE.
- `output_addr` in 16: base word address; captured on `start`.
- `in_valid` in 1: digest on `in_h0..in_h7` is valid.
- `in_ready` out 1: block accepts a digest this cycle.
- `in_h0` .. `in_h7` in 32 each: digest words.
- `mem_clk` out 1: equals `clk`.
- `mem_we` out 1: registered write enable.
- `mem_addr` out 16: registered write address.
- `mem_write_data` out 32: registered write data.
- `done` out 1: high exactly when the state is IDLE.

## Operation
- States are IDLE, WAIT and WRITE.
- **IDLE**: `in_ready`=0 and `mem_we`=0. When `start`=1:
  - capture `output_addr` into `base`;
  - clear `acc_cnt`, `wr_cnt` and `word_idx`;
  - empty the FIFO;
  - go to WAIT.
  - `start` in any other state is ignored.
- **Accept side** (WAIT or WRITE):
  - `in_ready` = !fifo_full && (`acc_cnt` < `NUM_NONCES`), computed from registered state only.
  - A handshake (`in_valid` && `in_ready`) pushes {h0..h7} and increments `acc_cnt`.
  - No push-on-full bypass: a simultaneous pop when full does not raise `in_ready` in that cycle.
- **WAIT**:
  - If the FIFO is non-empty: pop the head into `dig_reg`, set `word_idx`=0, issue word 0, go to WRITE.
  - Otherwise `mem_we`<=0.
- **Issue word n**: `mem_we`<=1, `mem_addr`<=`base` + `wr_cnt`*`WORDS_PER_DIGEST` + n, `mem_write_data`<=h[n]. Addition is 16-bit and wraps modulo 2^16.
- **WRITE**, one word per cycle:
  - If `word_idx` < `WORDS_PER_DIGEST`-1: increment `word_idx` and issue the next word.
  - Otherwise the digest is complete: `wr_cnt`++.
    - If the new `wr_cnt` == `NUM_NONCES`: `mem_we`<=0, go to IDLE.
    - Else if the FIFO is non-empty: pop and issue word 0 of the next digest, with no bubble.
    - Else: `mem_we`<=0, go to WAIT.
- Digests are written in arrival order. Slot k of the job goes to `base` + k*`WORDS_PER_DIGEST`.

## Timing
- Reset values:
  - state IDLE;
  - `done`=1, `in_ready`=0;
  - `mem_we`=0, `mem_addr`=0, `mem_write_data`=0;
  - FIFO empty, all counters 0.
- `start` sampled at edge S: `done`=0 and `in_ready`=1 after S.
- Digest accepted at edge E into an empty FIFO while in WAIT: word 0 is presented with `mem_we`=1 after edge E+1.
- Each following word is presented one edge later.
- Sustained throughput is one word per cycle, i.e. one digest per `WORDS_PER_DIGEST` cycles.
- `mem_we` falls at the same edge that enters IDLE, and `done`=1 from that edge on.
- Reset asserted mid-job:
  - `mem_we` drops to 0 immediately (asynchronous);
  - the FIFO and all counters clear;
  - the partial job is discarded.
- `in_valid` while `in_ready`=0: no push, and the data is not sampled.

## Structure
- Package `sha256_wb_pkg` holds:
  - the state enum {IDLE, WAIT, WRITE} as a 2-bit logic enum;
  - the digest struct typedef (eight 32-bit words);
  - the address-width constant (16).
- Sub-module `digest_fifo`: synchronous FIFO of digest structs.
  - Parameter: `DEPTH`.
  - Ports: push, pop, din, dout (head, read combinationally), full, empty.
  - Same `clk`/`reset_n` as the parent.
- The parent holds the FSM, counters and memory output registers.

## Test plan
- **Reset/idle**: hold `reset_n`=0, then release. Required: `done`=1, `in_ready`=0, `mem_we`=0, `mem_addr`=0 and `mem_write_data`=0, with no write before `start`.
- **Single-word mode**: defaults, `output_addr`=16'h0100, 16 digests with h0=32'hA000_0000+k sent one per cycle. Required: 16 writes to 0x0100..0x010F with data A000_0000..A000_000F, then `done`=1.
- **Full-digest mode**: `WORDS_PER_DIGEST`=8, `NUM_NONCES`=2, base 0x0020. Required: 16 consecutive `mem_we` cycles, addr 0x0020..0x002F, data h0..h7 of digest 0 then digest 1, with no bubble when digest 1 was already buffered.
- **Backpressure/full**: `FIFO_DEPTH`=2, `WORDS_PER_DIGEST`=8, `in_valid` held high. Required:
  - `in_ready` low while the FIFO holds 2 entries;
  - no digest lost or duplicated;
  - `acc_cnt` stops at `NUM_NONCES` and `in_ready` stays 0 afterwards.
- **Address wrap**: base 16'hFFFE, `NUM_NONCES`=4, 1 word each. Required: writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **Reset mid-operation**: assert `reset_n`=0 during digest 3 of 16. Required: `mem_we`=0 immediately. After release and a new `start` with base 0x0200, writes begin at 0x0200 with the first new digest.
